// File: rtl/regfile_wb_if.sv
// Write-back / decode bus of the integer register file.
// The pipeline side drives writes and read indices; the register file answers with read data and the write decode.
interface regfile_wb_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] rd_addr_a;
    logic [ADDR_WIDTH-1:0] rd_addr_b;
    logic [DATA_WIDTH-1:0] rd_data_a;
    logic [DATA_WIDTH-1:0] rd_data_b;
    logic [NUM_REGS-1:0]   wr_onehot;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, wr_onehot
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, wr_onehot
    );
endinterface

// File: rtl/regfile_wb.sv
// Integer register file with 31 writable registers, a hardwired zero register at the top index and two async read ports.
// Define REGFILE_BYPASS_EN to forward a same-cycle write-back value to the read ports.
module regfile_wb #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input logic         clk,
    input logic         reset,
    regfile_wb_if.slave bus
);
    localparam int                    NUM_REGS   = 2 ** ADDR_WIDTH;
    localparam int                    NUM_GROUPS = NUM_REGS / 8;
    localparam int                    ZERO_IDX   = NUM_REGS - 1;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR  = '1;

    logic [NUM_GROUPS-1:0] groupEn;
    logic [NUM_REGS-1:0]   onehot;
    logic [DATA_WIDTH-1:0] regs_q [ZERO_IDX];
    logic [DATA_WIDTH-1:0] regs_d [ZERO_IDX];

    // First decoder stage: upper index bits select one 3:8 group, gated by wr_en.
    always_comb begin
        groupEn = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            groupEn[g] = bus.wr_en && (bus.wr_addr[ADDR_WIDTH-1:3] == g[ADDR_WIDTH-4:0]);
        end
    end

    always_comb begin
        onehot = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            for (int k = 0; k < 8; k++) begin
                onehot[g*8 + k] = groupEn[g] && (bus.wr_addr[2:0] == k[2:0]);
            end
        end
        onehot[ZERO_IDX] = 1'b0;
    end

    assign bus.wr_onehot = onehot;

    always_comb begin
        for (int i = 0; i < ZERO_IDX; i++) begin
            regs_d[i] = onehot[i] ? bus.wr_data : regs_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ZERO_IDX; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ZERO_IDX; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    function automatic logic [DATA_WIDTH-1:0] readPort(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] value;
        value = '0;
        if (addr != ZERO_ADDR) begin
            value = regs_q[addr];
        end
`ifdef REGFILE_BYPASS_EN
        // Write-through keeps decode from stalling on a register being written back this cycle.
        if (reset && bus.wr_en && (bus.wr_addr == addr) && (addr != ZERO_ADDR)) begin
            value = bus.wr_data;
        end
`else
`endif
        return value;
    endfunction

    always_comb begin
        bus.rd_data_a = readPort(bus.rd_addr_a);
        bus.rd_data_b = readPort(bus.rd_addr_b);
    end
endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: directed scenarios plus random traffic against an array model of the register file.
module tb_regfile_wb;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [63:0] model [32];

    regfile_wb_if #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) rf ();

    regfile_wb #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (rf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] expectedRead(input logic [4:0] addr);
        if (addr == 5'd31) return 64'h0;
`ifdef REGFILE_BYPASS_EN
        if (reset && rf.wr_en && (rf.wr_addr == addr)) return rf.wr_data;
`endif
        return model[addr];
    endfunction

    function automatic logic [31:0] expectedOnehot();
        logic [31:0] v;
        v = 32'h0;
        if (rf.wr_en && (rf.wr_addr != 5'd31)) v = 32'h1 << rf.wr_addr;
        return v;
    endfunction

    task automatic applyStimulus(input logic en, input logic [4:0] wa, input logic [63:0] wd,
                                 input logic [4:0] ra, input logic [4:0] rb);
        rf.wr_en     = en;
        rf.wr_addr   = wa;
        rf.wr_data   = wd;
        rf.rd_addr_a = ra;
        rf.rd_addr_b = rb;
        #1;
    endtask

    task automatic checkOutput(input string tag);
        logic [63:0] expA;
        logic [63:0] expB;
        logic [31:0] expOh;
        expA  = expectedRead(rf.rd_addr_a);
        expB  = expectedRead(rf.rd_addr_b);
        expOh = expectedOnehot();
        checks++;
        assert (rf.rd_data_a === expA) else begin
            errors++;
            $error("[TB] FAIL %s rd_data_a observed %h expected %h", tag, rf.rd_data_a, expA);
        end
        checks++;
        assert (rf.rd_data_b === expB) else begin
            errors++;
            $error("[TB] FAIL %s rd_data_b observed %h expected %h", tag, rf.rd_data_b, expB);
        end
        checks++;
        assert (rf.wr_onehot === expOh) else begin
            errors++;
            $error("[TB] FAIL %s wr_onehot observed %h expected %h", tag, rf.wr_onehot, expOh);
        end
    endtask

    // Clock edge: the model commits whatever write was presented before the edge.
    task automatic stepCycle();
        @(posedge clk);
        if (reset && rf.wr_en && (rf.wr_addr != 5'd31)) model[rf.wr_addr] = rf.wr_data;
        #1;
    endtask

    task automatic dropReset();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 64'h0;
        #1;
    endtask

    initial begin
        logic [4:0]  wa;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [63:0] wd;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) model[i] = 64'h0;
        reset = 1'b0;
        applyStimulus(1'b0, 5'd0, 64'h0, 5'd0, 5'd0);

        $display("[TB] reset sweep");
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 5'd0, 64'h0, 5'(i), 5'(31 - i));
            checkOutput("reset_sweep");
        end
        applyStimulus(1'b1, 5'd5, 64'hABCD, 5'd5, 5'd5);
        checkOutput("reset_decode");
        stepCycle();
        checkOutput("reset_write_ignored");

        #2;
        reset = 1'b1;
        $display("[TB] write and read all");
        for (int i = 0; i < 31; i++) begin
            applyStimulus(1'b1, 5'(i), 64'h1000_0000_0000_0000 + 64'(i), 5'd0, 5'd31);
            stepCycle();
        end
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 5'd0, 64'h0, 5'(i), 5'((i + 7) % 32));
            checkOutput("read_all");
        end

        $display("[TB] zero register");
        applyStimulus(1'b1, 5'd31, 64'hDEAD_BEEF_CAFE_F00D, 5'd31, 5'd30);
        checkOutput("zero_write_decode");
        stepCycle();
        applyStimulus(1'b0, 5'd0, 64'h0, 5'd31, 5'd31);
        checkOutput("zero_read");

        $display("[TB] wr_en gating");
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 5'd4);
            checkOutput("gate_off");
            stepCycle();
        end
        applyStimulus(1'b1, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 5'd4);
        checkOutput("gate_on");
        stepCycle();

        $display("[TB] same-cycle read of write target");
        applyStimulus(1'b1, 5'd7, 64'h11, 5'd0, 5'd1);
        stepCycle();
        applyStimulus(1'b1, 5'd7, 64'h22, 5'd7, 5'd7);
        checkOutput("same_cycle_before");
        stepCycle();
        applyStimulus(1'b0, 5'd7, 64'h0, 5'd7, 5'd7);
        checkOutput("same_cycle_after");

        $display("[TB] random traffic");
        for (int c = 0; c < 300; c++) begin
            wa = 5'($urandom_range(0, 31));
            wd = {$urandom, $urandom};
            ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            applyStimulus(1'($urandom_range(0, 1)), wa, wd, ra, rb);
            checkOutput("random");
            stepCycle();
        end

        $display("[TB] async reset mid-operation");
        applyStimulus(1'b1, 5'd3, 64'h33, 5'd0, 5'd0);
        stepCycle();
        applyStimulus(1'b0, 5'd0, 64'h0, 5'd3, 5'd3);
        checkOutput("pre_reset");
        dropReset();
        checkOutput("async_reset_clear");
        applyStimulus(1'b1, 5'd3, 64'h44, 5'd3, 5'd4);
        checkOutput("reset_bypass_off");
        stepCycle();
        checkOutput("reset_write_lost");
        #2;
        reset = 1'b1;
        applyStimulus(1'b1, 5'd3, 64'h55, 5'd0, 5'd1);
        stepCycle();
        applyStimulus(1'b0, 5'd0, 64'h0, 5'd3, 5'd31);
        checkOutput("post_reset_write");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
